// File: rtl/fifo_sync_param_if.sv
// Write/read handshake and status bundle between a FIFO and its user.
interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] i_data;
  logic              i_en_write;
  logic              i_en_read;
  logic              i_clear;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_full;
  logic              o_empty;
  logic              o_almost_full;
  logic              o_almost_empty;
  logic [CW-1:0]     o_count;
  logic              o_overflow;
  logic              o_underflow;

  modport master (
    output i_data, i_en_write, i_en_read, i_clear,
    input  o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_data, i_en_write, i_en_read, i_clear,
    output o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: 1-cycle registered read, occupancy count,
// threshold flags, drop-on-full / reject-on-empty error pulses, synchronous flush.
module fifo_sync_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_TH  = DEPTH - 2,
  parameter int AE_TH  = 2
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  fifo_sync_param_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              full;
  logic              empty;
  logic              rd_acc;
  logic              wr_acc;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A write into a full FIFO is still taken when a read frees a slot the same edge.
  assign rd_acc = bus.i_en_read && !empty;
  assign wr_acc = bus.i_en_write && (!full || rd_acc);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.i_clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PW'(1);
        data_q <= mem[rd_ptr];
      end
      count       <= count_nxt;
      valid_q     <= rd_acc;
      overflow_q  <= bus.i_en_write && !wr_acc;
      underflow_q <= bus.i_en_read && !rd_acc;
    end
  end

  // Storage needs no reset; stale entries are never readable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (wr_acc && !bus.i_clear) mem[wr_ptr] <= bus.i_data;
  end

  assign bus.o_data         = data_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_full         = full;
  assign bus.o_empty        = empty;
  assign bus.o_almost_full  = (count >= CW'(AF_TH));
  assign bus.o_almost_empty = (count <= CW'(AE_TH));
  assign bus.o_count        = count;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at DATA_W=8, DEPTH=16.
module tb_fifo_sync_param;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fifo_sync_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

  fifo_sync_param #(.DATA_W(8), .DEPTH(16)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    bus.i_en_write = wr;
    bus.i_data     = d;
    bus.i_en_read  = rd;
    bus.i_clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_flags(input string tag);
    check({tag, "_empty"}, 32'(bus.o_empty), 1);
    check({tag, "_aempty"}, 32'(bus.o_almost_empty), 1);
    check({tag, "_full"}, 32'(bus.o_full), 0);
    check({tag, "_afull"}, 32'(bus.o_almost_full), 0);
    check({tag, "_count"}, 32'(bus.o_count), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_en_write = 1'b0;
    bus.i_en_read  = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_data     = 8'h00;

    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_flags("rst");
    check("rst_data", 32'(bus.o_data), 0);
    check("rst_valid", 32'(bus.o_valid), 0);
    check("rst_ovf", 32'(bus.o_overflow), 0);
    check("rst_unf", 32'(bus.o_underflow), 0);

    // 2: fill, overflow, drain
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_count", 32'(bus.o_count), 32'(i));
      check("fill_afull", 32'(bus.o_almost_full), (i >= 14) ? 1 : 0);
      check("fill_full", 32'(bus.o_full), (i == 16) ? 1 : 0);
      check("fill_aempty", 32'(bus.o_almost_empty), (i <= 2) ? 1 : 0);
    end
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_pulse", 32'(bus.o_overflow), 1);
    check("ovf_count", 32'(bus.o_count), 16);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_clear", 32'(bus.o_overflow), 0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_valid", 32'(bus.o_valid), 1);
      check("drain_data", 32'(bus.o_data), 32'(i));
      check("drain_count", 32'(bus.o_count), 32'(16 - i));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_valid", 32'(bus.o_valid), 0);
    check("idle_empty", 32'(bus.o_empty), 1);
    check("idle_hold", 32'(bus.o_data), 32'h10);

    // 3: underflow, then simultaneous read/write while empty
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_pulse", 32'(bus.o_underflow), 1);
    check("unf_valid", 32'(bus.o_valid), 0);
    check("unf_data", 32'(bus.o_data), 32'h10);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    check("rw_empty_unf", 32'(bus.o_underflow), 1);
    check("rw_empty_count", 32'(bus.o_count), 1);
    check("rw_empty_valid", 32'(bus.o_valid), 0);
    check("rw_empty_data", 32'(bus.o_data), 32'h10);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("rd_5a_valid", 32'(bus.o_valid), 1);
    check("rd_5a_data", 32'(bus.o_data), 32'h5A);
    check("rd_5a_unf", 32'(bus.o_underflow), 0);
    check("rd_5a_count", 32'(bus.o_count), 0);

    // 4: read+write while full, pointers wrap
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("refill_full", 32'(bus.o_full), 1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'h77, 1'b1, 1'b0);
      check("rwf_count", 32'(bus.o_count), 16);
      check("rwf_ovf", 32'(bus.o_overflow), 0);
      check("rwf_valid", 32'(bus.o_valid), 1);
      check("rwf_data", 32'(bus.o_data), 32'(i));
    end
    for (int i = 5; i <= 20; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_valid", 32'(bus.o_valid), 1);
      check("wrap_data", 32'(bus.o_data), (i <= 16) ? 32'(i) : 32'h77);
    end
    check("wrap_empty", 32'(bus.o_empty), 1);

    // 5: flush beats simultaneous read and write
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
    check("load5_count", 32'(bus.o_count), 5);
    step(1'b1, 8'h33, 1'b1, 1'b1);
    check("clr_count", 32'(bus.o_count), 0);
    check("clr_empty", 32'(bus.o_empty), 1);
    check("clr_valid", 32'(bus.o_valid), 0);
    check("clr_data_hold", 32'(bus.o_data), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_unf", 32'(bus.o_underflow), 1);
    check("clr_unf_valid", 32'(bus.o_valid), 0);
    check("clr_unf_count", 32'(bus.o_count), 0);

    // 6: asynchronous reset between edges
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    check("load8_count", 32'(bus.o_count), 8);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_flags("arst");
    check("arst_data", 32'(bus.o_data), 0);
    #2 rst_n = 1'b1;
    step(1'b1, 8'h42, 1'b0, 1'b0);
    check("post_wr_count", 32'(bus.o_count), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rd_valid", 32'(bus.o_valid), 1);
    check("post_rd_data", 32'(bus.o_data), 32'h42);
    check("post_rd_empty", 32'(bus.o_empty), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
